// File: rtl/fft_sample_loader_if.sv
// Sample-in / RAM-write-out bundle between the ADC stream, the FFT loader and FFT_controller.
// slave is the loader's view; master is the view of whoever drives samples and fft_done.
interface fft_sample_loader_if #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 18,
    parameter int SAMPLE_WIDTH = 12
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    fft_done;
    logic                    fft_start;
    logic                    load_en;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    dropped;

    modport master (
        output sample_valid, sample, fft_done,
        input  fft_start, load_en, we, waddr, wdata_r, wdata_i, dropped
    );

    modport slave (
        input  sample_valid, sample, fft_done,
        output fft_start, load_en, we, waddr, wdata_r, wdata_i, dropped
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Collects 2^ADDR_WIDTH ADC samples into the FFT RAM in bit-reversed order, then hands the RAM off.
// Latency: sample_valid -> RAM write 1 cycle; last sample_valid -> fft_start 2 cycles.
// No backpressure: samples arriving while the FFT owns the RAM are discarded and flagged via dropped.
module fft_sample_loader #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 18,
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    fft_sample_loader_if.slave bus
);
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   idx;
    logic signed [SAMPLE_WIDTH-1:0] s;

    // Offset-binary to two's complement is just an MSB flip.
    assign s = {~bus.sample[SAMPLE_WIDTH-1], bus.sample[SAMPLE_WIDTH-2:0]};

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOAD;
            idx           <= '0;
            bus.load_en   <= 1'b1;
            bus.fft_start <= 1'b0;
            bus.we        <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata_r   <= '0;
            bus.wdata_i   <= '0;
            bus.dropped   <= 1'b0;
        end else begin
            bus.fft_start <= 1'b0;
            bus.we        <= 1'b0;
            bus.dropped   <= 1'b0;
            bus.wdata_i   <= '0;
            case (state)
                LOAD: begin
                    bus.load_en <= 1'b1;
                    if (bus.sample_valid) begin
                        bus.we      <= 1'b1;
                        bus.waddr   <= bitrev(idx);
                        bus.wdata_r <= DATA_WIDTH'(s);
                        idx         <= idx + 1'b1;
                        if (&idx) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    bus.fft_start <= 1'b1;
                    bus.load_en   <= 1'b0;
                    bus.dropped   <= bus.sample_valid;
                    state         <= WAIT;
                end
                WAIT: begin
                    bus.dropped <= bus.sample_valid;
                    // Ownership returns on the edge that sees fft_done; that cycle's sample is still lost.
                    if (bus.fft_done) begin
                        bus.load_en <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        bus.load_en <= 1'b0;
                    end
                end
                default: begin
                    bus.load_en <= 1'b1;
                    idx         <= '0;
                    state       <= LOAD;
                end
            endcase
        end
    end
endmodule
